controller_button_events: RTL and testbench

Register-mapped button state and edge-event block sitting directly downstream of the controller serial interface. Each time a new parallel sample of all controllers is presented, it debounces the samples and tracks the stable held state. It also records sticky pressed and released events. The CPU reads all of this through a small read-clear register window.

---
 rtl/controller_button_events.sv | 135 +++++++++++++
 tb/tb_controller_button_events.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_button_events.sv
// controller_button_events
//   Debounced button state and sticky edge events for a set of controllers,
//   fed by parallel samples from the controller serial interface and read by
//   the CPU through a small read-clear register window.
//
// Ports:
//   clk_in           system clock, all state updates on posedge
//   rst              synchronous active-high reset
//   buttons_in_LIST  raw button bits, 8 per controller (1 = pressed)
//   sample_valid     one-cycle pulse marking a fresh sample
//   cpu_rd           read strobe, one cycle per access
//   cpu_addr         {controller index, reg_sel[1:0]}
//                    reg_sel: 0 HELD, 1 PRESSED (rc), 2 RELEASED (rc), 3 FRAME
//   cpu_data_out     registered read data, holds between reads
module controller_button_events #(
    parameter int unsigned NUM_CONTROLLERS  = 2,
    parameter int unsigned DEBOUNCE_SAMPLES = 2,
    localparam int unsigned CPU_ADDR_W      = $clog2(NUM_CONTROLLERS) + 2
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic [8*NUM_CONTROLLERS-1:0] buttons_in_LIST,
    input  logic                         sample_valid,
    input  logic                         cpu_rd,
    input  logic [CPU_ADDR_W-1:0]        cpu_addr,
    output logic [7:0]                   cpu_data_out
);

    localparam logic [2:0] DebCount = 3'(DEBOUNCE_SAMPLES);

    logic [7:0] cand_q     [NUM_CONTROLLERS];
    logic [7:0] cand_d     [NUM_CONTROLLERS];
    logic [2:0] cnt_q      [NUM_CONTROLLERS];
    logic [2:0] cnt_d      [NUM_CONTROLLERS];
    logic [7:0] held_q     [NUM_CONTROLLERS];
    logic [7:0] held_d     [NUM_CONTROLLERS];
    logic [7:0] pressed_q  [NUM_CONTROLLERS];
    logic [7:0] pressed_d  [NUM_CONTROLLERS];
    logic [7:0] released_q [NUM_CONTROLLERS];
    logic [7:0] released_d [NUM_CONTROLLERS];
    logic [7:0] frame_q, frame_d;
    logic [7:0] rdata_q, rdata_d;

    logic [CPU_ADDR_W-1:0] rd_idx;
    logic [1:0]            rd_sel;

    assign rd_idx = cpu_addr >> 2;
    assign rd_sel = cpu_addr[1:0];

    always_comb begin
        logic [7:0] lane;
        logic [7:0] cand_n;
        logic [2:0] cnt_n;
        logic [7:0] held_n;
        logic       hit;
        logic       clr_press;
        logic       clr_release;

        frame_d = frame_q;
        rdata_d = rdata_q;
        if (sample_valid) begin
            frame_d = frame_q + 8'd1;
        end
        // Out-of-range controller index falls through to 0x00.
        if (cpu_rd) begin
            rdata_d = 8'h00;
        end

        for (int c = 0; c < NUM_CONTROLLERS; c++) begin
            lane        = buttons_in_LIST[8*c +: 8];
            cand_n      = cand_q[c];
            cnt_n       = cnt_q[c];
            held_n      = held_q[c];
            hit         = (rd_idx == CPU_ADDR_W'(c));
            clr_press   = cpu_rd && hit && (rd_sel == 2'd1);
            clr_release = cpu_rd && hit && (rd_sel == 2'd2);

            if (sample_valid) begin
                if (lane == cand_q[c]) begin
                    cnt_n = (cnt_q[c] >= DebCount) ? DebCount : cnt_q[c] + 3'd1;
                end else begin
                    cand_n = lane;
                    cnt_n  = 3'd1;
                end
                if (cnt_n >= DebCount) begin
                    held_n = cand_n;
                end
            end

            cand_d[c] = cand_n;
            cnt_d[c]  = cnt_n;
            held_d[c] = held_n;
            // Clear first, then OR in new edges so a same-cycle event survives the read.
            pressed_d[c]  = (clr_press ? 8'h00 : pressed_q[c]) | (held_n & ~held_q[c]);
            released_d[c] = (clr_release ? 8'h00 : released_q[c]) | (~held_n & held_q[c]);

            // Read returns pre-edge contents.
            if (cpu_rd && hit) begin
                unique case (rd_sel)
                    2'd0: rdata_d = held_q[c];
                    2'd1: rdata_d = pressed_q[c];
                    2'd2: rdata_d = released_q[c];
                    2'd3: rdata_d = frame_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                cand_q[c]     <= 8'h00;
                cnt_q[c]      <= 3'd0;
                held_q[c]     <= 8'h00;
                pressed_q[c]  <= 8'h00;
                released_q[c] <= 8'h00;
            end
            frame_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                cand_q[c]     <= cand_d[c];
                cnt_q[c]      <= cnt_d[c];
                held_q[c]     <= held_d[c];
                pressed_q[c]  <= pressed_d[c];
                released_q[c] <= released_d[c];
            end
            frame_q <= frame_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_data_out = rdata_q;

endmodule

// File: tb/tb_controller_button_events.sv
// Scoreboard bench: read tasks push the expected byte, per-DUT monitors pop
// and compare one cycle after each read strobe. A second instance with three
// controllers covers the out-of-range index path.
module tb_controller_button_events;

    typedef struct {
        int         dut;
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    // Default instance: 2 controllers, 3-bit address.
    logic [15:0] btn0   = '0;
    logic        sv0    = 1'b0;
    logic        rd0    = 1'b0;
    logic [2:0]  addr0  = '0;
    logic [7:0]  dout0;

    // Three-controller instance: 4-bit address.
    logic [23:0] btn3   = '0;
    logic        sv3    = 1'b0;
    logic        rd3    = 1'b0;
    logic [3:0]  addr3  = '0;
    logic [7:0]  dout3;

    always #5 clk_in = ~clk_in;

    controller_button_events u_dut0 (
        .clk_in          (clk_in),
        .rst             (rst),
        .buttons_in_LIST (btn0),
        .sample_valid    (sv0),
        .cpu_rd          (rd0),
        .cpu_addr        (addr0),
        .cpu_data_out    (dout0)
    );

    controller_button_events #(
        .NUM_CONTROLLERS  (3),
        .DEBOUNCE_SAMPLES (2)
    ) u_dut3 (
        .clk_in          (clk_in),
        .rst             (rst),
        .buttons_in_LIST (btn3),
        .sample_valid    (sv3),
        .cpu_rd          (rd3),
        .cpu_addr        (addr3),
        .cpu_data_out    (dout3)
    );

    task automatic check(input int d, input logic [7:0] act);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read dut%0d got=%02h expected=<none>", d, act);
        end else begin
            e = sb_q.pop_front();
            if (e.dut != d || act !== e.exp) begin
                failures++;
                $display("FAIL %s dut%0d got=%02h expected=%02h (dut%0d)",
                         e.name, d, act, e.exp, e.dut);
            end
        end
    endtask

    always @(posedge clk_in) begin
        logic pend0;
        pend0 = rd0 && !rst;
        #1;
        if (pend0) check(0, dout0);
    end

    always @(posedge clk_in) begin
        logic pend3;
        pend3 = rd3 && !rst;
        #1;
        if (pend3) check(3, dout3);
    end

    task automatic push(input int d, input string name, input logic [7:0] exp);
        exp_t e;
        e.dut  = d;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic sample0(input logic [15:0] data);
        @(negedge clk_in);
        btn0 = data;
        sv0  = 1'b1;
        @(negedge clk_in);
        sv0  = 1'b0;
    endtask

    task automatic read0(input logic [2:0] a, input logic [7:0] exp, input string name);
        @(negedge clk_in);
        rd0   = 1'b1;
        addr0 = a;
        push(0, name, exp);
        @(negedge clk_in);
        rd0   = 1'b0;
    endtask

    task automatic sample_read0(input logic [15:0] data, input logic [2:0] a,
                                input logic [7:0] exp, input string name);
        @(negedge clk_in);
        btn0  = data;
        sv0   = 1'b1;
        rd0   = 1'b1;
        addr0 = a;
        push(0, name, exp);
        @(negedge clk_in);
        sv0   = 1'b0;
        rd0   = 1'b0;
    endtask

    task automatic sample3(input logic [23:0] data);
        @(negedge clk_in);
        btn3 = data;
        sv3  = 1'b1;
        @(negedge clk_in);
        sv3  = 1'b0;
    endtask

    task automatic read3(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk_in);
        rd3   = 1'b1;
        addr3 = a;
        push(3, name, exp);
        @(negedge clk_in);
        rd3   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: every address reads zero.
        do_reset();
        for (int a = 0; a < 8; a++) begin
            read0(3'(a), 8'h00, $sformatf("reset_addr%0d", a));
        end

        // Debounce of 2 on lane0.
        sample0(16'h0001);
        read0(3'd0, 8'h00, "deb_held_after1");
        sample0(16'h0001);
        read0(3'd0, 8'h01, "deb_held_after2");
        read0(3'd1, 8'h01, "deb_pressed");
        read0(3'd1, 8'h00, "deb_pressed_cleared");

        // Glitch on lane1 never reaches held.
        sample0(16'h0001);
        read0(3'd4, 8'h00, "glitch_held_s0");
        sample0(16'h0801);
        read0(3'd4, 8'h00, "glitch_held_s1");
        read0(3'd5, 8'h00, "glitch_pressed_s1");
        sample0(16'h0001);
        read0(3'd4, 8'h00, "glitch_held_s2");
        sample0(16'h0001);
        read0(3'd4, 8'h00, "glitch_held_s3");
        read0(3'd5, 8'h00, "glitch_pressed_s3");
        read0(3'd0, 8'h01, "glitch_lane0_held");

        // Release with the read-clear landing on the same edge as the event.
        do_reset();
        sample0(16'h0081);
        sample0(16'h0081);
        read0(3'd0, 8'h81, "rel_held81");
        read0(3'd1, 8'h81, "rel_pressed81");
        sample0(16'h0080);
        sample_read0(16'h0080, 3'd2, 8'h00, "rel_same_cycle_read");
        read0(3'd2, 8'h01, "rel_event_kept");
        read0(3'd2, 8'h00, "rel_cleared");
        read0(3'd0, 8'h80, "rel_held80");

        // FRAME wrap using back-to-back sample pulses.
        do_reset();
        @(negedge clk_in);
        btn0 = 16'h0000;
        sv0  = 1'b1;
        repeat (256) @(negedge clk_in);
        sv0  = 1'b0;
        read0(3'd3, 8'h00, "frame_256");
        read0(3'd7, 8'h00, "frame_256_c1");
        sample0(16'h0000);
        read0(3'd3, 8'h01, "frame_257");
        read0(3'd7, 8'h01, "frame_257_c1");
        read0(3'd0, 8'h00, "frame_held_zero");

        // Reset mid-debounce discards the partial count.
        do_reset();
        sample0(16'h00FF);
        do_reset();
        sample0(16'h00FF);
        read0(3'd0, 8'h00, "midrst_held_1st");
        read0(3'd3, 8'h01, "midrst_frame");
        sample0(16'h00FF);
        read0(3'd0, 8'hFF, "midrst_held_2nd");
        read0(3'd1, 8'hFF, "midrst_pressed");

        // Out-of-range controller index on the three-controller instance.
        do_reset();
        sample3(24'h000400);
        sample3(24'h000400);
        read3(4'b1101, 8'h00, "oor_pressed");
        read3(4'b1111, 8'h00, "oor_frame");
        read3(4'b0101, 8'h04, "oor_no_clear_c1");
        read3(4'b1011, 8'h02, "c2_frame");
        read3(4'b0101, 8'h00, "c1_pressed_cleared");

        repeat (3) @(negedge clk_in);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
